// File: rtl/bus_hs_pkg.sv
// Shared definitions for valid/ready handshake stages: state encoding,
// default data width and a state-to-occupancy helper.
package bus_hs_pkg;

    // Default data bus width for handshake stages.
    localparam int unsigned HS_WIDTH_DEFAULT = 32;

    // Buffer occupancy states: no beat, one beat in main, main plus skid.
    typedef enum logic [1:0] {
        HS_EMPTY = 2'd0,
        HS_BUSY  = 2'd1,
        HS_FULL  = 2'd2
    } hs_state_e;

    // Number of buffered beats implied by a state; unknown encodings read as empty.
    function automatic logic [1:0] hs_count(input hs_state_e state);
        logic [1:0] cnt;
        case (state)
            HS_EMPTY: cnt = 2'd0;
            HS_BUSY:  cnt = 2'd1;
            HS_FULL:  cnt = 2'd2;
            default:  cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/bus_skid_buffer.sv
// Full register slice for a valid/ready handshake. valid_o, data_o and
// ready_o all come straight from flops, so neither the forward data path
// nor the slave's backpressure path passes combinationally through this
// stage. A main register feeds the slave; a skid register catches the one
// beat that can arrive in the cycle after the slave stalls.
import bus_hs_pkg::*;

module bus_skid_buffer #(
    parameter int unsigned WIDTH = HS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    hs_state_e        state_r;
    hs_state_e        state_next_s;
    logic             valid_r;
    logic             ready_r;
    logic             valid_next_s;
    logic             ready_next_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] main_next_s;
    logic [WIDTH-1:0] skid_next_s;
    logic             in_fire_s;
    logic             out_fire_s;

    // Handshake events, built only from flopped outputs and raw inputs.
    always_comb begin
        in_fire_s  = valid_i & ready_r;
        out_fire_s = valid_r & ready_i;
    end

    // Next state and register loads; everything holds unless a transfer moves it.
    always_comb begin
        state_next_s = state_r;
        main_next_s  = main_r;
        skid_next_s  = skid_r;
        case (state_r)
            HS_EMPTY: begin
                if (in_fire_s) begin
                    main_next_s  = data_i;
                    state_next_s = HS_BUSY;
                end else begin
                    state_next_s = HS_EMPTY;
                end
            end
            HS_BUSY: begin
                if (in_fire_s && out_fire_s) begin
                    main_next_s  = data_i;
                    state_next_s = HS_BUSY;
                end else if (in_fire_s) begin
                    // Slave stalled while a new beat arrived: park it in skid.
                    skid_next_s  = data_i;
                    state_next_s = HS_FULL;
                end else if (out_fire_s) begin
                    // Main keeps its stale value; valid_o drops instead.
                    state_next_s = HS_EMPTY;
                end else begin
                    state_next_s = HS_BUSY;
                end
            end
            HS_FULL: begin
                // ready_o is low here, so no new beat can be accepted.
                if (out_fire_s) begin
                    main_next_s  = skid_r;
                    state_next_s = HS_BUSY;
                end else begin
                    state_next_s = HS_FULL;
                end
            end
            default: begin
                // Unreachable encoding: recover to a safe, empty buffer.
                state_next_s = HS_EMPTY;
            end
        endcase
    end

    // Output handshake flags follow the next state so they are ready the
    // same cycle the state register updates.
    always_comb begin
        if (state_next_s == HS_EMPTY) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = 1'b1;
        end
        if (state_next_s == HS_FULL) begin
            ready_next_s = 1'b0;
        end else begin
            ready_next_s = 1'b1;
        end
    end

    // State register and dedicated valid/ready output flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= HS_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            valid_r <= valid_next_s;
            ready_r <= ready_next_s;
        end
    end

    // Main and skid data registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_r <= {WIDTH{1'b0}};
            skid_r <= {WIDTH{1'b0}};
        end else begin
            main_r <= main_next_s;
            skid_r <= skid_next_s;
        end
    end

    // Outputs are taken directly from registers; count is a decode of state.
    always_comb begin
        valid_o = valid_r;
        ready_o = ready_r;
        data_o  = main_r;
        count_o = hs_count(state_r);
    end

endmodule

// File: tb/tb_bus_skid_buffer.sv
// Self-checking bench for bus_skid_buffer. Stimulus drives directed vectors
// shortly after each rising edge; a monitor samples on the falling edge,
// pushes every accepted beat into a scoreboard queue and pops/compares on
// every delivered beat, also checking stall stability and X-freedom.
module tb_bus_skid_buffer;

    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic         valid_i;
    logic         ready_o;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_i;
    logic [W-1:0] data_o;
    logic [1:0]   count_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb[$];

    bus_skid_buffer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_state(input string name, input logic v, input logic r,
                               input logic [1:0] c, input logic [W-1:0] d);
        check({name, ".valid_o"}, {31'd0, valid_o}, {31'd0, v});
        check({name, ".ready_o"}, {31'd0, ready_o}, {31'd0, r});
        check({name, ".count_o"}, {30'd0, count_o}, {30'd0, c});
        check({name, ".data_o"},  data_o, d);
    endtask

    // Discard expectations for beats lost to reset.
    always @(negedge rstn) sb.delete();

    logic         prev_valid = 1'b0;
    logic         prev_fire  = 1'b0;
    logic         prev_rstn  = 1'b0;
    logic [W-1:0] prev_data  = '0;

    // Monitor: scoreboard push/pop, stall stability and X checks.
    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
        end else begin
            checks++;
            if ($isunknown({valid_o, ready_o, data_o, count_o})) begin
                errors++;
                $display("FAIL no_x: outputs v=%b r=%b d=%h c=%b", valid_o, ready_o, data_o, count_o);
            end
            if (prev_rstn && prev_valid && !prev_fire) begin
                check("stall_valid", {31'd0, valid_o}, 32'd1);
                check("stall_data", data_o, prev_data);
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got beat %h expected none", data_o);
                end else begin
                    check("sb_order", data_o, sb.pop_front());
                end
            end
            if (valid_i && ready_o) sb.push_back(data_i);
        end
        prev_rstn  = rstn;
        prev_valid = valid_o;
        prev_fire  = valid_o & ready_i;
        prev_data  = data_o;
    end

    initial begin
        rstn    = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b0;
        data_i  = 32'h0000_00A5;

        // Reset held with valid_i asserted.
        repeat (3) step();
        check_state("reset", 1'b0, 1'b1, 2'd0, 32'h0);

        // Release; first beat shows one cycle later.
        rstn    = 1'b1;
        ready_i = 1'b1;
        step();
        check_state("first_beat", 1'b1, 1'b1, 2'd1, 32'h0000_00A5);
        valid_i = 1'b0;
        step();
        check_state("first_drain", 1'b0, 1'b1, 2'd0, 32'h0000_00A5);

        // Back-to-back streaming at full rate.
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1;
            data_i  = i;
            step();
            check_state("stream", 1'b1, 1'b1, 2'd1, i);
        end
        valid_i = 1'b0;
        step();
        check_state("stream_end", 1'b0, 1'b1, 2'd0, 32'h10);

        // Stall: 0x20 on data_o when ready_i drops, 0x21 lands in skid.
        valid_i = 1'b1;
        data_i  = 32'h20;
        step();
        check_state("stall_load", 1'b1, 1'b1, 2'd1, 32'h20);
        ready_i = 1'b0;
        data_i  = 32'h21;
        step();
        check_state("stall_full", 1'b1, 1'b0, 2'd2, 32'h20);
        check("stall_skid", dut.skid_r, 32'h21);
        data_i = 32'h22;
        step();
        check_state("stall_hold", 1'b1, 1'b0, 2'd2, 32'h20);
        ready_i = 1'b1;
        step();
        check_state("stall_release", 1'b1, 1'b1, 2'd1, 32'h21);
        step();
        check_state("stall_next", 1'b1, 1'b1, 2'd1, 32'h22);
        valid_i = 1'b0;
        step();
        check_state("stall_empty", 1'b0, 1'b1, 2'd0, 32'h22);

        // Single beat drains after exactly one valid cycle.
        valid_i = 1'b1;
        data_i  = 32'h55;
        step();
        check_state("drain_one", 1'b1, 1'b1, 2'd1, 32'h55);
        valid_i = 1'b0;
        step();
        check_state("drain_empty", 1'b0, 1'b1, 2'd0, 32'h55);

        // Reset while FULL discards both beats immediately.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'h60;
        step();
        data_i = 32'h61;
        step();
        check_state("pre_reset_full", 1'b1, 1'b0, 2'd2, 32'h60);
        rstn = 1'b0;
        #1;
        check_state("reset_mid_full", 1'b0, 1'b1, 2'd0, 32'h0);
        valid_i = 1'b0;
        step();
        rstn    = 1'b1;
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 32'h77;
        step();
        check_state("after_reset", 1'b1, 1'b1, 2'd1, 32'h77);
        valid_i = 1'b0;
        step();
        check_state("after_reset_drain", 1'b0, 1'b1, 2'd0, 32'h77);

        // Random valid/ready traffic, checked by the monitor.
        for (int i = 0; i < 10000; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 3) != 0);
            data_i  = $urandom;
            step();
        end

        // Drain with a bounded wait, then everything accepted must be out.
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 8 && valid_o; i++) step();
        step();
        check("final_count", {30'd0, count_o}, 32'd0);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
